uart_send: RTL and testbench

UART transmitter: the transmit-side counterpart of the board's USB-UART receive path. It accepts bytes from on-chip logic through a valid/ready handshake and buffers them in a small FIFO. Each byte is serialised on the USB-UART TX pin as an 8N1 frame: start bit 0, eight data bits LSB first, stop bit 1. The default bit timing is 9600 baud from a 100 MHz clock, the same rate as the receive path.

---
 rtl/uart_send.sv | 194 +++++++++++++++++++
 tb/tb_uart_send.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_send.sv
// uart_send: buffered 8N1 UART transmitter.
//
// Bytes offered on a valid/ready handshake are queued in a small FIFO and
// sent LSB first, framed by one start bit (0) and one stop bit (1). Each
// bit lasts BAUD_DIVIDER clock cycles. Consecutive queued bytes go out as
// contiguous frames with no idle gap between them.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   valid  data holds a byte to send
//   data   byte to send, captured on the accepting edge
//   ready  FIFO has a free slot
//   busy   frame in progress or FIFO non-empty
//   dout   registered serial line, idles high
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line high, waiting for a queued byte
// START | driving the start bit (0)
// DATA  | driving shift_q[0], eight bits, LSB first
// STOP  | driving the stop bit (1), then chain into the next byte
module uart_send #(
  parameter int BAUD_DIVIDER = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       dout
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIVIDER);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIVIDER - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic              dout_q, dout_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic bit_end;

  assign ready      = (count_q < CNT_FULL);
  assign push       = valid && ready;
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign bit_end    = (baud_cnt_q == BAUD_LAST);
  assign dout       = dout_q;

  // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= data;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_mem_q[rd_ptr_q];
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit so frames stay contiguous.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_mem_q[rd_ptr_q];
            bit_idx_d = 3'd0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // The line level is derived from the next state so the registered output
  // changes on the same edge as the state register.
  always_comb begin
    dout_d = 1'b1;
    case (state_d)
      START:   dout_d = 1'b0;
      DATA:    dout_d = shift_d[0];
      default: dout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      dout_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      dout_q     <= dout_d;
    end
  end

endmodule

// File: tb/tb_uart_send.sv
module tb_uart_send;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BAUD;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       busy;
  logic       dout;

  int checks;
  int failures;
  int cyc;

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] tx_q[$];

  uart_send #(
    .BAUD_DIVIDER(BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .valid(valid),
    .data (data),
    .ready(ready),
    .busy (busy),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line decoder: samples mid-bit on falling clock edges, counting from the
  // first cycle the start bit is seen.
  int         dec_cnt;
  logic       dec_active;
  logic [7:0] dec_shift;
  initial begin
    dec_active = 1'b0;
    dec_cnt    = 0;
    dec_shift  = 8'h00;
  end

  always @(negedge clk) begin
    if (rst) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (dout === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == BAUD / 2) begin
        check_val("start_bit", 32'(dout), 32'd0);
      end else if (dec_cnt > BAUD / 2 && dec_cnt < 9 * BAUD + BAUD / 2 &&
                   ((dec_cnt - BAUD / 2) % BAUD) == 0) begin
        dec_shift = {dout, dec_shift[7:1]};
      end else if (dec_cnt == 9 * BAUD + BAUD / 2) begin
        check_val("stop_bit", 32'(dout), 32'd1);
        rx_q.push_back(dec_shift);
        dec_active = 1'b0;
      end
    end
  end

  // Offers tx_q in order, holding valid and retrying whenever ready is low.
  task automatic send_all(input int budget);
    int idx;
    int n;
    idx = 0;
    n   = 0;
    while (idx < tx_q.size() && n < budget) begin
      @(negedge clk);
      valid = 1'b1;
      data  = tx_q[idx];
      if (ready) idx++;
      n++;
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = 8'h00;
    check_val("send_budget", 32'(idx), 32'(tx_q.size()));
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", 32'(n < limit), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    start_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] exp_b [5];
    int         lvl;
    int         bad;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    valid    = 1'b0;
    data     = 8'h00;

    // Reset state and quiet line.
    repeat (3) @(negedge clk);
    check_val("rst_dout", 32'(dout), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_dout", 32'(dout), 32'd1);
    check_val("reset_ready", 32'(ready), 32'd1);
    check_val("reset_busy", 32'(busy), 32'd0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (dout !== 1'b1) bad++;
    end
    check_val("idle_hold", 32'(bad), 32'd0);

    // Single byte 0x55, checked cycle by cycle.
    clear_logs();
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h55;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = 8'hFF;
    @(negedge clk);
    check_val("single_busy_early", 32'(busy), 32'd1);
    check_val("single_dout_early", 32'(dout), 32'd1);
    b = 8'h55;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      lvl = i / BAUD;
      if (lvl == 0) check_val("single_bit", 32'(dout), 32'd0);
      else if (lvl == 9) check_val("single_bit", 32'(dout), 32'd1);
      else check_val("single_bit", 32'(dout), 32'(b[lvl-1]));
      if (i == FRAME - 1) check_val("single_busy_last", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check_val("single_busy_end", 32'(busy), 32'd0);
    check_val("single_dout_end", 32'(dout), 32'd1);
    repeat (4) @(negedge clk);
    check_val("single_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check_val("single_byte", 32'(rx_q[0]), 32'h55);

    // Burst of five with retry on ready.
    clear_logs();
    exp_b = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    tx_q  = {8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    send_all(2000);
    wait_idle(6 * FRAME);
    check_val("burst_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      check_val("burst_byte", 32'(rx_q[i]), 32'(exp_b[i]));
    end
    for (int i = 1; i < start_q.size(); i++) begin
      check_val("burst_spacing", 32'(start_q[i] - start_q[i-1]), 32'(FRAME));
    end

    // Full FIFO: valid held with incrementing data; only 0x10..0x14 fit.
    clear_logs();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = 8'h10 + 8'(k);
      check_val("full_ready", 32'(ready), (k <= 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = 8'h00;
    wait_idle(6 * FRAME);
    check_val("full_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      check_val("full_byte", 32'(rx_q[i]), 32'h10 + 32'(i));
    end

    // Reset during data bit 3 of 0xC3 with two bytes queued.
    clear_logs();
    tx_q = {8'hC3, 8'hAA, 8'hBB};
    send_all(100);
    repeat (70) @(negedge clk);
    check_val("midrst_bit3", 32'(dout), 32'd0);
    check_val("midrst_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_dout", 32'(dout), 32'd1);
    check_val("midrst_ready", 32'(ready), 32'd1);
    check_val("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    bad = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (dout !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_val("midrst_quiet", 32'(bad), 32'd0);
    check_val("midrst_no_rx", 32'(rx_q.size()), 32'd0);
    tx_q = {8'h12};
    send_all(100);
    wait_idle(2 * FRAME);
    check_val("midrst_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check_val("midrst_byte", 32'(rx_q[0]), 32'h12);

    // Loopback sweep of every byte value.
    clear_logs();
    tx_q.delete();
    for (int v = 0; v < 256; v++) tx_q.push_back(8'(v));
    send_all(260 * FRAME);
    wait_idle(6 * FRAME);
    check_val("sweep_count", 32'(rx_q.size()), 32'd256);
    for (int v = 0; v < 256 && v < rx_q.size(); v++) begin
      check_val("sweep_byte", 32'(rx_q[v]), 32'(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
